unified_mem_arbiter: RTL and testbench

//  Shares one single-ported unified instruction/data memory between the IF fetch port and the MEM-stage load/store port.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/unified_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package riscv_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_BE_W   = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  we;
        logic [ARB_BE_W-1:0]   be;
        logic [ARB_DATA_W-1:0] wdata;
    } arb_req_t;

    // Reads always present every byte lane to the memory.
    function automatic logic [ARB_BE_W-1:0] arb_be(input logic we, input logic [ARB_BE_W-1:0] be);
        return we ? be : '1;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between the IF fetch port and the MEM load/store port.
//   state | meaning
//   IDLE  | no access outstanding; arbitrate between fetch and data
//   FETCH | fetch access on the memory bus, may be killed by a flush
//   DATA  | load/store access on the memory bus
module unified_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int STARVE_LIMIT = 4,
    parameter int WAIT_MAX     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int WC_W = $clog2(WAIT_MAX);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(WAIT_MAX - 1);

    arb_state_t          state_q, state_d;
    arb_req_t            req_q, req_d;
    logic                mem_req_q, mem_req_d;
    logic                kill_q, kill_d;
    logic [SC_W-1:0]     starve_q, starve_d;
    logic [WC_W-1:0]     wait_q, wait_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic if_cand, d_cand, grant_data, killed, timeout;

    // A port whose ack is showing this cycle still holds its request; it must not be re-granted.
    assign if_cand    = if_req && !if_ack_q && !if_flush;
    assign d_cand     = d_req && !d_ack_q;
    assign grant_data = d_cand && !(if_cand && (starve_q == STARVE_MAX));
    assign killed     = kill_q || if_flush;
    assign timeout    = !mem_ack && (wait_q == WAIT_LAST);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        mem_req_d  = mem_req_q;
        kill_d     = kill_q;
        starve_d   = starve_q;
        wait_d     = wait_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        err_d      = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d     = DATA;
                    req_d.addr  = d_addr;
                    req_d.we    = d_we;
                    req_d.be    = arb_be(d_we, d_be);
                    req_d.wdata = d_we ? d_wdata : '0;
                    mem_req_d   = 1'b1;
                    wait_d      = '0;
                    kill_d      = 1'b0;
                    if (if_cand && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + SC_W'(1);
                    end
                end else if (if_cand) begin
                    state_d     = FETCH;
                    req_d.addr  = if_addr;
                    req_d.we    = 1'b0;
                    req_d.be    = '1;
                    req_d.wdata = '0;
                    mem_req_d   = 1'b1;
                    wait_d      = '0;
                    kill_d      = 1'b0;
                    starve_d    = '0;
                end
            end

            FETCH: begin
                if (if_flush) begin
                    kill_d = 1'b1;
                end
                if (mem_ack || timeout) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    kill_d    = 1'b0;
                    if (!killed) begin
                        if_ack_d   = 1'b1;
                        err_d      = !mem_ack;
                        if_rdata_d = mem_ack ? mem_rdata : '0;
                    end
                end else begin
                    wait_d = wait_q + WC_W'(1);
                end
            end

            DATA: begin
                if (mem_ack || timeout) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    err_d     = !mem_ack;
                    d_rdata_d = (mem_ack && !req_q.we) ? mem_rdata : '0;
                end else begin
                    wait_d = wait_q + WC_W'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            mem_req_q  <= 1'b0;
            kill_q     <= 1'b0;
            starve_q   <= '0;
            wait_q     <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            mem_req_q  <= mem_req_d;
            kill_q     <= kill_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign if_stall  = if_req && !if_ack_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_stall   = d_req && !d_ack_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = req_q.we;
    assign mem_be    = req_q.be;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: vector table plus hand-written contention, starvation, flush and reset sequences.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, if_ack, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ack, d_stall;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        err;
    logic        mem_req, mem_we, mem_ack;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .WAIT_MAX(16)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
        .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        return (a == 32'h100) ? 32'h0050_0093 : {lo ^ 16'h5A5A, ~lo};
    endfunction

    // Memory model: acks ack_dly cycles after mem_req rises; 0 means never.
    int ack_dly = 1;
    int rq_cnt  = 0;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req !== 1'b1) begin
                rq_cnt    = 0;
                mem_ack   = 1'b0;
                mem_rdata = '0;
            end else begin
                rq_cnt++;
                mem_ack   = (ack_dly != 0) && (rq_cnt == ack_dly);
                mem_rdata = mem_ack ? mem_fn(mem_addr) : 32'h0;
            end
        end
    end

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t sb_q[$];

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_ack === 1'b1 || d_ack === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: if_ack=%b d_ack=%b if_rdata=%h d_rdata=%h, none expected",
                             if_ack, d_ack, if_rdata, d_rdata);
                end else begin
                    e = sb_q.pop_front();
                    chk("ack_port", 32'({if_ack, d_ack}), e.is_d ? 32'd1 : 32'd2);
                    chk("ack_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
                    chk("ack_err", 32'(err), 32'(e.err));
                end
            end else if (err === 1'b1) begin
                chk("err_without_ack", 32'(err), 32'd0);
            end
        end
    end

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;
    gnt_t gnt_q[$];

    initial begin
        gnt_t cur;
        logic prev;
        prev = 1'b0;
        cur  = '{1'b0, 4'h0, 32'h0, 32'h0};
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1 && prev !== 1'b1) begin
                cur = '{mem_we, mem_be, mem_addr, mem_wdata};
                gnt_q.push_back(cur);
            end else if (mem_req === 1'b1) begin
                chk("mem_stable", 32'(mem_we === cur.we && mem_be === cur.be &&
                                      mem_addr === cur.addr && mem_wdata === cur.wdata), 32'd1);
            end
            prev = mem_req;
        end
    end

    task automatic expect_grant(input string name, input logic we, input logic [3:0] be,
                                input logic [31:0] addr, input logic [31:0] wdata);
        gnt_t g;
        if (gnt_q.size() == 0) begin
            chk({name, "_present"}, 32'd0, 32'd1);
        end else begin
            g = gnt_q.pop_front();
            chk({name, "_addr"}, g.addr, addr);
            chk({name, "_we_be"}, 32'({g.we, g.be}), 32'({we, be}));
            chk({name, "_wdata"}, g.wdata, wdata);
        end
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_cyc;
        int          exp_mreq;
    } vec_t;

    task automatic apply_vec(input vec_t v);
        int cyc, stalls, mreq;
        bit got;
        cyc = 0; stalls = 0; mreq = 0; got = 0;
        sb_q.push_back('{v.is_d, v.exp_rdata, v.exp_err});
        @(posedge clk);
        #2;
        ack_dly = v.dly;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if ((v.is_d ? d_ack : if_ack) === 1'b1) begin
                got = 1;
            end else begin
                cyc++;
                if ((v.is_d ? d_stall : if_stall) === 1'b1) stalls++;
            end
            if (mem_req === 1'b1) mreq++;
        end
        chk("vec_ack_seen", 32'(got), 32'd1);
        if (!got) sb_q.delete();
        chk("vec_latency", 32'(cyc), 32'(v.exp_cyc));
        chk("vec_stall_cycles", 32'(stalls), 32'(v.exp_cyc));
        chk("vec_mem_req_cycles", 32'(mreq), 32'(v.exp_mreq));
        @(posedge clk);
        #2;
        d_req  = 1'b0;
        if_req = 1'b0;
        expect_grant("vec_grant", v.is_d & v.we, (v.is_d & v.we) ? v.be : 4'hF, v.addr,
                     (v.is_d & v.we) ? v.wdata : 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    vec_t vecs[7];

    initial begin
        logic [31:0] prev_rd;
        bit fd, dd, got, changed;
        int dn;

        vecs[0] = '{0, 0, 4'h0, 32'h100, 32'h0,        1, 32'h0050_0093,  0, 2,  1};
        vecs[1] = '{1, 0, 4'h0, 32'h040, 32'h5555_AAAA, 1, mem_fn(32'h40),  0, 2,  1};
        vecs[2] = '{1, 1, 4'h3, 32'h044, 32'h1234_5678, 2, 32'h0,          0, 3,  2};
        vecs[3] = '{0, 0, 4'h0, 32'h104, 32'h0,        4, mem_fn(32'h104), 0, 5,  4};
        vecs[4] = '{1, 0, 4'hF, 32'h080, 32'h0,        0, 32'h0,          1, 17, 16};
        vecs[5] = '{0, 0, 4'h0, 32'h108, 32'h0,        0, 32'h0,          1, 17, 16};
        vecs[6] = '{1, 1, 4'hF, 32'h048, 32'hDEAD_BEEF, 1, 32'h0,          0, 2,  1};

        reset = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_acks", 32'({if_ack, d_ack, err}), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_mem_fields", 32'({mem_we, mem_be}) | mem_addr | mem_wdata, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;

        for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

        // Simultaneous store and fetch: data wins, fetch follows.
        sb_q.push_back('{1, 32'h0, 0});
        sb_q.push_back('{0, 32'h0050_0093, 0});
        @(posedge clk);
        #2;
        ack_dly = 1;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h40; d_wdata = 32'hCAFE_BABE;
        if_req = 1'b1; if_addr = 32'h100;
        fd = 0; dd = 0;
        for (int c = 0; c < 40 && !(fd && dd); c++) begin
            @(negedge clk);
            if (if_ack === 1'b1) fd = 1;
            if (d_ack === 1'b1) dd = 1;
            @(posedge clk);
            #2;
            if (fd) if_req = 1'b0;
            if (dd) d_req = 1'b0;
        end
        chk("contend_done", 32'({fd, dd}), 32'd3);
        if_req = 1'b0; d_req = 1'b0;
        expect_grant("contend_first", 1'b1, 4'hF, 32'h40, 32'hCAFE_BABE);
        expect_grant("contend_second", 1'b0, 4'hF, 32'h100, 32'h0);

        // Starvation: data held, fetch pending; a branch flush hides fetch in each data-ack cycle.
        for (int i = 0; i < 4; i++) sb_q.push_back('{1, mem_fn(32'h200), 0});
        sb_q.push_back('{0, mem_fn(32'h300), 0});
        sb_q.push_back('{1, mem_fn(32'h200), 0});
        @(posedge clk);
        #2;
        ack_dly = 1;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200; d_wdata = '0;
        if_req = 1'b1; if_addr = 32'h300;
        fd = 0; dn = 0;
        for (int c = 0; c < 200 && !(fd && dn >= 5); c++) begin
            @(negedge clk);
            if (d_ack === 1'b1) dn++;
            if (if_ack === 1'b1) fd = 1;
            if (d_ack === 1'b1 && !fd) if_flush = 1'b1;
            @(posedge clk);
            #2;
            if_flush = 1'b0;
            if (fd) if_req = 1'b0;
            if (dn >= 5) d_req = 1'b0;
        end
        chk("starve_fetch_done", 32'(fd), 32'd1);
        chk("starve_data_acks", 32'(dn), 32'd5);
        if_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 4; i++) expect_grant("starve_data", 1'b0, 4'hF, 32'h200, 32'h0);
        expect_grant("starve_fetch", 1'b0, 4'hF, 32'h300, 32'h0);
        expect_grant("starve_data_again", 1'b0, 4'hF, 32'h200, 32'h0);

        // Flush one cycle after a fetch grant kills it; the new pc is fetched afterwards.
        prev_rd = if_rdata;
        sb_q.push_back('{0, mem_fn(32'h600), 0});
        @(posedge clk);
        #2;
        ack_dly = 4;
        if_req = 1'b1; if_addr = 32'h500;
        @(posedge clk);
        #2;
        if_flush = 1'b1; if_addr = 32'h600;
        @(posedge clk);
        #2;
        if_flush = 1'b0;
        got = 0; changed = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (if_ack === 1'b1) got = 1;
            else if (if_rdata !== prev_rd) changed = 1;
        end
        chk("flush_new_fetch_ack", 32'(got), 32'd1);
        chk("flush_rdata_held", 32'(changed), 32'd0);
        @(posedge clk);
        #2;
        if_req = 1'b0;
        expect_grant("flush_killed", 1'b0, 4'hF, 32'h500, 32'h0);
        expect_grant("flush_new_pc", 1'b0, 4'hF, 32'h600, 32'h0);

        // Reset in the middle of a hung load.
        @(posedge clk);
        #2;
        ack_dly = 0;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h700;
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("rstmid_mem_req_before", 32'(mem_req), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_mem_req_after", 32'(mem_req), 32'd0);
        chk("rstmid_no_ack", 32'({if_ack, d_ack, err}), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        expect_grant("rstmid_grant", 1'b0, 4'hF, 32'h700, 32'h0);
        apply_vec(vecs[1]);

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("grants_drained", 32'(gnt_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
